// File: rtl/pwm_pkg.sv
// Shared state encoding and mode constants for the PWM wave generator.
package pwm_pkg;

  typedef enum logic [1:0] {IDLE, ON, OFF} pwm_state_t;

  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/pwm_time_regs.sv
// Shadow/active on/off time registers; a load lands in shadow and is copied
// to active only when the generator signals a period boundary.
module pwm_time_regs #(
  parameter int N           = 8,
  parameter int DEFAULT_ON  = 5,
  parameter int DEFAULT_OFF = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] on_time_in,
  input  logic [N-1:0] off_time_in,
  input  logic         commit,
  output logic [N-1:0] on_act,
  output logic [N-1:0] off_act,
  output logic [N-1:0] on_eff,
  output logic [N-1:0] off_eff
);

  logic [N-1:0] on_shadow;
  logic [N-1:0] off_shadow;
  logic         pending;

  // Values the active pair will hold after a commit in this cycle.
  assign on_eff  = pending ? on_shadow  : on_act;
  assign off_eff = pending ? off_shadow : off_act;

  // A load coinciding with a commit keeps pending set, so it applies one boundary later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      on_shadow  <= N'(DEFAULT_ON);
      off_shadow <= N'(DEFAULT_OFF);
      on_act     <= N'(DEFAULT_ON);
      off_act    <= N'(DEFAULT_OFF);
      pending    <= 1'b0;
    end else begin
      if (commit && pending) begin
        on_act  <= on_shadow;
        off_act <= off_shadow;
      end
      if (load) begin
        on_shadow  <= on_time_in;
        off_shadow <= off_time_in;
        pending    <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pwm_wave_gen.sv
// Programmable PWM / square-wave generator with continuous and burst modes.
// s_wave is decoded from the registered state, so the output cannot glitch.
module pwm_wave_gen
  import pwm_pkg::*;
#(
  parameter int N           = 8,
  parameter int M           = 8,
  parameter int DEFAULT_ON  = 5,
  parameter int DEFAULT_OFF = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] on_time_in,
  input  logic [N-1:0] off_time_in,
  input  logic         mode,
  input  logic         start,
  input  logic [M-1:0] burst_len,
  output logic         s_wave,
  output logic         busy,
  output logic         period_tick,
  output logic         done
);

  pwm_state_t   state_reg, state_next;
  logic [N-1:0] phase_cnt, phase_next;
  logic [M-1:0] period_cnt, period_next;
  logic [M-1:0] burst_len_reg, burst_next;
  logic         mode_reg, mode_next;
  logic         tick_next, done_next;
  logic         commit, period_end, trigger, zero_eff;
  logic [N-1:0] on_act, off_act, on_eff, off_eff;

  pwm_time_regs #(
    .N          (N),
    .DEFAULT_ON (DEFAULT_ON),
    .DEFAULT_OFF(DEFAULT_OFF)
  ) u_time_regs (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .on_time_in (on_time_in),
    .off_time_in(off_time_in),
    .commit     (commit),
    .on_act     (on_act),
    .off_act    (off_act),
    .on_eff     (on_eff),
    .off_eff    (off_eff)
  );

  assign trigger  = en && ((mode == MODE_CONT) || (start && (burst_len != '0)));
  assign zero_eff = (on_eff == '0) && (off_eff == '0);

  always_comb begin
    state_next  = state_reg;
    phase_next  = phase_cnt;
    period_next = period_cnt;
    mode_next   = mode_reg;
    burst_next  = burst_len_reg;
    tick_next   = 1'b0;
    done_next   = 1'b0;
    commit      = 1'b0;
    period_end  = 1'b0;

    if (state_reg != IDLE && !en) begin
      state_next  = IDLE;
      phase_next  = '0;
      period_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          phase_next  = '0;
          period_next = '0;
          if (trigger && !zero_eff) begin
            commit     = 1'b1;
            mode_next  = mode;
            burst_next = burst_len;
            state_next = (on_eff != '0) ? ON : OFF;
          end
        end
        ON: begin
          if (phase_cnt == on_act - 1'b1) begin
            phase_next = '0;
            if (off_act != '0) state_next = OFF;
            else               period_end = 1'b1;
          end else begin
            phase_next = phase_cnt + 1'b1;
          end
        end
        OFF: begin
          if (phase_cnt == off_act - 1'b1) begin
            phase_next = '0;
            period_end = 1'b1;
          end else begin
            phase_next = phase_cnt + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase

      // Shared end-of-period handling: commit new times, tick, and check burst completion.
      if (period_end) begin
        commit      = 1'b1;
        tick_next   = 1'b1;
        period_next = period_cnt + 1'b1;
        if (mode_reg == MODE_BURST && (period_cnt + 1'b1) == burst_len_reg) begin
          state_next  = IDLE;
          done_next   = 1'b1;
          period_next = '0;
        end else if (zero_eff) begin
          state_next  = IDLE;
          period_next = '0;
        end else begin
          state_next = (on_eff != '0) ? ON : OFF;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      phase_cnt     <= '0;
      period_cnt    <= '0;
      mode_reg      <= MODE_CONT;
      burst_len_reg <= '0;
      period_tick   <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_reg     <= state_next;
      phase_cnt     <= phase_next;
      period_cnt    <= period_next;
      mode_reg      <= mode_next;
      burst_len_reg <= burst_next;
      period_tick   <= tick_next;
      done          <= done_next;
    end
  end

  assign s_wave = (state_reg == ON);
  assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_pwm_wave_gen.sv
// Directed bench for pwm_wave_gen: per-cycle waveform, tick and done patterns
// are written out by hand for each scenario.
module tb_pwm_wave_gen;
  import pwm_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       load;
  logic [7:0] on_time_in;
  logic [7:0] off_time_in;
  logic       mode;
  logic       start;
  logic [7:0] burst_len;
  logic       s_wave;
  logic       busy;
  logic       period_tick;
  logic       done;

  int checks   = 0;
  int failures = 0;

  pwm_wave_gen dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load       (load),
    .on_time_in (on_time_in),
    .off_time_in(off_time_in),
    .mode       (mode),
    .start      (start),
    .burst_len  (burst_len),
    .s_wave     (s_wave),
    .busy       (busy),
    .period_tick(period_tick),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Each character of wave/tk/dn is the expected value just after one rising edge.
  task automatic expect_cycles(input string tag, input int n, input string wave,
                               input string tk, input string dn);
    for (int i = 0; i < n; i++) begin
      step();
      check_output($sformatf("%s.wave[%0d]", tag, i), s_wave, wave.getc(i) == "1");
      check_output($sformatf("%s.tick[%0d]", tag, i), period_tick, tk.getc(i) == "1");
      check_output($sformatf("%s.done[%0d]", tag, i), done, dn.getc(i) == "1");
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] on_t, input logic [7:0] off_t);
    load        = 1'b1;
    on_time_in  = on_t;
    off_time_in = off_t;
    step();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; load = 1'b0; on_time_in = '0; off_time_in = '0;
    mode = MODE_CONT; start = 1'b0; burst_len = '0;
    step(); step();
    check_output("rst.wave", s_wave, 1'b0);
    check_output("rst.busy", busy, 1'b0);
    check_output("rst.tick", period_tick, 1'b0);
    check_output("rst.done", done, 1'b0);
    reset = 1'b0;
    step();

    // Continuous mode with default 5/3 timing.
    en = 1'b1;
    expect_cycles("cont", 16, "1111100011111000", "0000000010000000", "0000000000000000");
    check_output("cont.busy", busy, 1'b1);

    // Load 2/6 in the middle of an ON phase; current period still finishes as 5/3.
    expect_cycles("pre", 2, "11", "10", "00");
    load = 1'b1; on_time_in = 8'd2; off_time_in = 8'd6;
    expect_cycles("ld", 1, "1", "0", "0");
    load = 1'b0;
    expect_cycles("reload", 14, "11000110000001", "00000100000001", "00000000000000");
    en = 1'b0;
    expect_cycles("stop", 1, "0", "0", "0");
    check_output("stop.busy", busy, 1'b0);

    // Burst of three 3/2 periods.
    apply_stimulus(8'd3, 8'd2);
    mode = MODE_BURST; burst_len = 8'd3; start = 1'b1; en = 1'b1;
    expect_cycles("burst0", 1, "1", "0", "0");
    start = 1'b0;
    check_output("burst.busy", busy, 1'b1);
    expect_cycles("burst", 15, "110011100111000", "000010000100001", "000000000000001");
    check_output("burst.idle_busy", busy, 1'b0);
    expect_cycles("burst_after", 1, "0", "0", "0");
    check_output("burst.after_busy", busy, 1'b0);

    // Zero on-time: output stays low, ticks every 4 cycles.
    en = 1'b0; mode = MODE_CONT;
    apply_stimulus(8'd0, 8'd4);
    en = 1'b1;
    expect_cycles("on0", 9, "000000000", "000010001", "000000000");
    check_output("on0.busy", busy, 1'b1);

    // Zero off-time: output stays high, ticks every 4 cycles.
    en = 1'b0;
    apply_stimulus(8'd4, 8'd0);
    check_output("off0.idle_busy", busy, 1'b0);
    en = 1'b1;
    expect_cycles("off0", 9, "111111111", "000010001", "000000000");

    // Both zero: trigger ignored.
    en = 1'b0;
    apply_stimulus(8'd0, 8'd0);
    en = 1'b1;
    expect_cycles("zz", 3, "000", "000", "000");
    check_output("zz.busy", busy, 1'b0);

    // Drop en in the second ON cycle, then restart with a full 5/3 period.
    en = 1'b0;
    apply_stimulus(8'd5, 8'd3);
    en = 1'b1;
    expect_cycles("drop_on", 2, "11", "00", "00");
    en = 1'b0;
    expect_cycles("drop", 1, "0", "0", "0");
    check_output("drop.busy", busy, 1'b0);
    en = 1'b1;
    expect_cycles("resume", 9, "111110001", "000000001", "000000000");

    // Asynchronous reset mid-burst after loading 2/2.
    en = 1'b0;
    step();
    apply_stimulus(8'd2, 8'd2);
    mode = MODE_BURST; burst_len = 8'd5; start = 1'b1; en = 1'b1;
    expect_cycles("rb0", 1, "1", "0", "0");
    start = 1'b0;
    expect_cycles("rb", 2, "10", "00", "00");
    #2;
    reset = 1'b1;
    #1;
    check_output("arst.busy", busy, 1'b0);
    check_output("arst.wave", s_wave, 1'b0);
    check_output("arst.tick", period_tick, 1'b0);
    check_output("arst.done", done, 1'b0);
    mode = MODE_CONT; burst_len = '0; en = 1'b1;
    step();
    reset = 1'b0;
    expect_cycles("post_rst", 9, "111110001", "000000001", "000000000");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
